// File: rtl/hash_table_pkg.sv
// Shared widths, opcodes, result codes and RAM entry layouts for the hash table engine.
package hash_table_pkg;
  localparam int KEY_WIDTH        = 32;
  localparam int VALUE_WIDTH      = 16;
  localparam int BUCKET_WIDTH     = 8;
  localparam int TABLE_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_SEARCH = 2'd1,
    OP_INSERT = 2'd2,
    OP_DELETE = 2'd3
  } opcode_t;

  typedef enum logic [2:0] {
    SEARCH_FOUND                     = 3'd0,
    SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
    INSERT_SUCCESS                   = 3'd2,
    INSERT_SUCCESS_SAME_KEY          = 3'd3,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
    DELETE_SUCCESS                   = 3'd5,
    DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6,
    INIT_SUCCESS                     = 3'd7
  } rescode_t;

  typedef struct packed {
    opcode_t                opcode;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;

  typedef struct packed {
    ht_command_t             cmd;
    rescode_t                rescode;
    logic [BUCKET_WIDTH-1:0] bucket;
    logic [VALUE_WIDTH-1:0]  found_value;
  } ht_result_t;

  typedef struct packed {
    logic [TABLE_ADDR_WIDTH-1:0] ptr;
    logic                        ptr_val;
  } head_ram_data_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic                        next_ptr_val;
  } ram_data_t;
endpackage

// File: rtl/hash_table_if.sv
// Command and result valid/ready streams of the hash table engine.
interface hash_table_if;
  import hash_table_pkg::*;

  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic [1:0]              cmd_opcode_i;
  logic [KEY_WIDTH-1:0]    cmd_key_i;
  logic [VALUE_WIDTH-1:0]  cmd_value_i;
  logic                    res_valid_o;
  logic                    res_ready_i;
  logic [1:0]              res_opcode_o;
  logic [KEY_WIDTH-1:0]    res_key_o;
  logic [VALUE_WIDTH-1:0]  res_value_o;
  logic [2:0]              res_rescode_o;
  logic [BUCKET_WIDTH-1:0] res_bucket_o;
  logic [VALUE_WIDTH-1:0]  res_found_value_o;

  modport slave (
    input  cmd_valid_i, cmd_opcode_i, cmd_key_i, cmd_value_i, res_ready_i,
    output cmd_ready_o, res_valid_o, res_opcode_o, res_key_o, res_value_o,
           res_rescode_o, res_bucket_o, res_found_value_o
  );

  modport master (
    output cmd_valid_i, cmd_opcode_i, cmd_key_i, cmd_value_i, res_ready_i,
    input  cmd_ready_o, res_valid_o, res_opcode_o, res_key_o, res_value_o,
           res_rescode_o, res_bucket_o, res_found_value_o
  );
endinterface

// File: rtl/ht_empty_ptr_storage.sv
// Free-address FIFO; reset (async or sync) makes it hold 0..DEPTH-1 in order, zero-latency read.
// Slots never written since reset read back their own index, so reloading costs one cycle.
module ht_empty_ptr_storage
  import hash_table_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        srst_i,
  input  logic                        rd_ack_i,
  output logic [TABLE_ADDR_WIDTH-1:0] rd_dat_o,
  output logic                        not_empty_o,
  input  logic                        wr_vld_i,
  input  logic [TABLE_ADDR_WIDTH-1:0] wr_dat_i
);
  localparam int DEPTH = 2**TABLE_ADDR_WIDTH;
  localparam logic [TABLE_ADDR_WIDTH:0] FULL_CNT = (TABLE_ADDR_WIDTH+1)'(DEPTH);

  logic [TABLE_ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [TABLE_ADDR_WIDTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [TABLE_ADDR_WIDTH:0]   cnt_q;
  logic                        wr_wrap_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= FULL_CNT;
      wr_wrap_q <= 1'b0;
    end else if (srst_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= FULL_CNT;
      wr_wrap_q <= 1'b0;
    end else begin
      if (rd_ack_i) rd_ptr_q <= rd_ptr_q + TABLE_ADDR_WIDTH'(1);
      if (wr_vld_i) begin
        wr_ptr_q <= wr_ptr_q + TABLE_ADDR_WIDTH'(1);
        if (&wr_ptr_q) wr_wrap_q <= 1'b1;
      end
      cnt_q <= cnt_q + (TABLE_ADDR_WIDTH+1)'(wr_vld_i) - (TABLE_ADDR_WIDTH+1)'(rd_ack_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_vld_i && !srst_i) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  // Until the write pointer wraps, only slots below it hold pushed addresses.
  assign rd_dat_o    = (!wr_wrap_q && (rd_ptr_q >= wr_ptr_q)) ? rd_ptr_q : mem_q[rd_ptr_q];
  assign not_empty_o = (cnt_q != '0);
endmodule

// File: rtl/hash_table_core.sv
// Chained hash table: one command in flight, one in-order result each; INIT ~2^BUCKET_WIDTH cycles,
// lookups 2 + 2 per chain entry. Result held until res_ready_i; cmd_ready_o only in IDLE.
module hash_table_core
  import hash_table_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  hash_table_if.slave  ht
);
  localparam int HEAD_DEPTH = 2**BUCKET_WIDTH;
  localparam int DATA_DEPTH = 2**TABLE_ADDR_WIDTH;
  localparam logic [TABLE_ADDR_WIDTH:0] MAX_STEP = (TABLE_ADDR_WIDTH+1)'(DATA_DEPTH-1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT_CLR  = 4'd1;
  localparam logic [3:0] S_READ_HEAD = 4'd2;
  localparam logic [3:0] S_READ_DATA = 4'd3;
  localparam logic [3:0] S_CMP       = 4'd4;
  localparam logic [3:0] S_ALLOC     = 4'd5;
  localparam logic [3:0] S_LINK      = 4'd6;
  localparam logic [3:0] S_UNLINK    = 4'd7;
  localparam logic [3:0] S_RESULT    = 4'd8;

  logic [3:0]                  state_q, state_d;
  ht_command_t                 cmd_q, cmd_d;
  logic [BUCKET_WIDTH-1:0]     bucket_q, bucket_d;
  rescode_t                    rescode_q, rescode_d;
  logic [VALUE_WIDTH-1:0]      found_value_q, found_value_d;
  logic [BUCKET_WIDTH-1:0]     init_cnt_q, init_cnt_d;
  logic                        auto_init_q, auto_init_d;
  logic [TABLE_ADDR_WIDTH-1:0] cur_ptr_q, cur_ptr_d, prev_ptr_q, prev_ptr_d, new_ptr_q, new_ptr_d;
  logic                        prev_val_q, prev_val_d, tail_val_q, tail_val_d;
  ram_data_t                   cur_q, cur_d, prev_q, prev_d;
  logic [TABLE_ADDR_WIDTH:0]   steps_q, steps_d;

  head_ram_data_t              head_ram [HEAD_DEPTH];
  ram_data_t                   data_ram [DATA_DEPTH];
  head_ram_data_t              head_rd_q, head_wdat;
  ram_data_t                   data_rd_q, data_wdat;
  logic                        head_we, data_we;
  logic [BUCKET_WIDTH-1:0]     head_raddr, head_waddr;
  logic [TABLE_ADDR_WIDTH-1:0] data_waddr;

  logic                        fifo_srst, fifo_pop, fifo_push, fifo_not_empty;
  logic [TABLE_ADDR_WIDTH-1:0] fifo_rd_dat;
  logic [3:0]                  miss_state;
  rescode_t                    miss_rescode;
  ht_result_t                  res;

  ht_empty_ptr_storage u_empty_ptr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .srst_i      (fifo_srst),
    .rd_ack_i    (fifo_pop),
    .rd_dat_o    (fifo_rd_dat),
    .not_empty_o (fifo_not_empty),
    .wr_vld_i    (fifo_push),
    .wr_dat_i    (cur_ptr_q)
  );

  // Head is read speculatively with the incoming key so it is ready in READ_HEAD.
  assign head_raddr = ht.cmd_key_i[KEY_WIDTH-1 -: BUCKET_WIDTH];

  always_ff @(posedge clk_i) begin
    if (head_we) head_ram[head_waddr] <= head_wdat;
    if (data_we) data_ram[data_waddr] <= data_wdat;
    head_rd_q <= head_ram[head_raddr];
    data_rd_q <= data_ram[cur_ptr_q];
  end

  always_comb begin
    miss_state   = S_RESULT;
    miss_rescode = SEARCH_NOT_SUCCESS_NO_ENTRY;
    case (cmd_q.opcode)
      OP_DELETE: miss_rescode = DELETE_NOT_SUCCESS_NO_ENTRY;
      OP_INSERT: begin
        if (fifo_not_empty) begin
          miss_state   = S_ALLOC;
          miss_rescode = INSERT_SUCCESS;
        end else begin
          miss_rescode = INSERT_NOT_SUCCESS_TABLE_IS_FULL;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    bucket_d      = bucket_q;
    rescode_d     = rescode_q;
    found_value_d = found_value_q;
    init_cnt_d    = init_cnt_q;
    auto_init_d   = auto_init_q;
    cur_ptr_d     = cur_ptr_q;
    prev_ptr_d    = prev_ptr_q;
    new_ptr_d     = new_ptr_q;
    prev_val_d    = prev_val_q;
    tail_val_d    = tail_val_q;
    cur_d         = cur_q;
    prev_d        = prev_q;
    steps_d       = steps_q;
    head_we       = 1'b0;
    head_waddr    = bucket_q;
    head_wdat     = '0;
    data_we       = 1'b0;
    data_waddr    = cur_ptr_q;
    data_wdat     = cur_q;
    fifo_srst     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ht.cmd_valid_i) begin
          cmd_d         = '{opcode: opcode_t'(ht.cmd_opcode_i), key: ht.cmd_key_i, value: ht.cmd_value_i};
          bucket_d      = ht.cmd_key_i[KEY_WIDTH-1 -: BUCKET_WIDTH];
          found_value_d = '0;
          init_cnt_d    = '0;
          state_d       = (opcode_t'(ht.cmd_opcode_i) == OP_INIT) ? S_INIT_CLR : S_READ_HEAD;
        end
      end
      S_INIT_CLR: begin
        head_we    = 1'b1;
        head_waddr = init_cnt_q;
        init_cnt_d = init_cnt_q + BUCKET_WIDTH'(1);
        if (&init_cnt_q) begin
          fifo_srst   = 1'b1;
          auto_init_d = 1'b0;
          rescode_d   = INIT_SUCCESS;
          state_d     = auto_init_q ? S_IDLE : S_RESULT;
        end
      end
      S_READ_HEAD: begin
        prev_val_d = 1'b0;
        steps_d    = '0;
        cur_ptr_d  = head_rd_q.ptr;
        tail_val_d = head_rd_q.ptr_val;
        if (head_rd_q.ptr_val) begin
          state_d = S_READ_DATA;
        end else begin
          state_d   = miss_state;
          rescode_d = miss_rescode;
        end
      end
      S_READ_DATA: state_d = S_CMP;
      S_CMP: begin
        cur_d   = data_rd_q;
        steps_d = steps_q + (TABLE_ADDR_WIDTH+1)'(1);
        if (data_rd_q.key == cmd_q.key) begin
          case (cmd_q.opcode)
            OP_INSERT: begin
              data_we         = 1'b1;
              data_wdat       = data_rd_q;
              data_wdat.value = cmd_q.value;
              rescode_d       = INSERT_SUCCESS_SAME_KEY;
              state_d         = S_RESULT;
            end
            OP_DELETE: state_d = S_UNLINK;
            default: begin
              found_value_d = data_rd_q.value;
              rescode_d     = SEARCH_FOUND;
              state_d       = S_RESULT;
            end
          endcase
        end else if (data_rd_q.next_ptr_val && (steps_q != MAX_STEP)) begin
          prev_d     = data_rd_q;
          prev_ptr_d = cur_ptr_q;
          prev_val_d = 1'b1;
          cur_ptr_d  = data_rd_q.next_ptr;
          state_d    = S_READ_DATA;
        end else begin
          state_d   = miss_state;
          rescode_d = miss_rescode;
        end
      end
      S_ALLOC: begin
        fifo_pop   = 1'b1;
        new_ptr_d  = fifo_rd_dat;
        data_we    = 1'b1;
        data_waddr = fifo_rd_dat;
        data_wdat  = '{key: cmd_q.key, value: cmd_q.value, next_ptr: '0, next_ptr_val: 1'b0};
        state_d    = S_LINK;
      end
      S_LINK: begin
        // cur_q/cur_ptr_q still describe the chain tail when the walk missed.
        if (tail_val_q) begin
          data_we                = 1'b1;
          data_wdat.next_ptr     = new_ptr_q;
          data_wdat.next_ptr_val = 1'b1;
        end else begin
          head_we   = 1'b1;
          head_wdat = '{ptr: new_ptr_q, ptr_val: 1'b1};
        end
        state_d = S_RESULT;
      end
      S_UNLINK: begin
        if (prev_val_q) begin
          data_we                = 1'b1;
          data_waddr             = prev_ptr_q;
          data_wdat              = prev_q;
          data_wdat.next_ptr     = cur_q.next_ptr;
          data_wdat.next_ptr_val = cur_q.next_ptr_val;
        end else begin
          head_we   = 1'b1;
          head_wdat = '{ptr: cur_q.next_ptr, ptr_val: cur_q.next_ptr_val};
        end
        fifo_push = 1'b1;
        rescode_d = DELETE_SUCCESS;
        state_d   = S_RESULT;
      end
      S_RESULT: begin
        if (ht.res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_INIT_CLR;
      auto_init_q   <= 1'b1;
      init_cnt_q    <= '0;
      cmd_q         <= '0;
      bucket_q      <= '0;
      rescode_q     <= SEARCH_FOUND;
      found_value_q <= '0;
      cur_ptr_q     <= '0;
      prev_ptr_q    <= '0;
      new_ptr_q     <= '0;
      prev_val_q    <= 1'b0;
      tail_val_q    <= 1'b0;
      cur_q         <= '0;
      prev_q        <= '0;
      steps_q       <= '0;
    end else begin
      state_q       <= state_d;
      auto_init_q   <= auto_init_d;
      init_cnt_q    <= init_cnt_d;
      cmd_q         <= cmd_d;
      bucket_q      <= bucket_d;
      rescode_q     <= rescode_d;
      found_value_q <= found_value_d;
      cur_ptr_q     <= cur_ptr_d;
      prev_ptr_q    <= prev_ptr_d;
      new_ptr_q     <= new_ptr_d;
      prev_val_q    <= prev_val_d;
      tail_val_q    <= tail_val_d;
      cur_q         <= cur_d;
      prev_q        <= prev_d;
      steps_q       <= steps_d;
    end
  end

  assign res = '{cmd: cmd_q, rescode: rescode_q, bucket: bucket_q, found_value: found_value_q};

  assign ht.cmd_ready_o       = (state_q == S_IDLE);
  assign ht.res_valid_o       = (state_q == S_RESULT);
  assign ht.res_opcode_o      = res.cmd.opcode;
  assign ht.res_key_o         = res.cmd.key;
  assign ht.res_value_o       = res.cmd.value;
  assign ht.res_rescode_o     = res.rescode;
  assign ht.res_bucket_o      = res.bucket;
  assign ht.res_found_value_o = res.found_value;
endmodule

// File: tb/tb_hash_table_core.sv
// Directed and random command streams for hash_table_core, checked against a key->value map model.
module tb_hash_table_core;
  import hash_table_pkg::*;

  localparam int CAPACITY = 2**TABLE_ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hash_table_if ifc ();
  hash_table_core dut (.clk_i(clk), .rst_i(rst_n), .ht(ifc));

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [VALUE_WIDTH-1:0] model [logic [KEY_WIDTH-1:0]];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] key, input logic [15:0] val,
                         input bit rnd_rdy);
    logic [2:0]  exp_rc;
    logic [15:0] exp_fv;
    int          cyc;
    bit          ok;
    bit          got;
    exp_fv = '0;
    case (op)
      2'd0: begin model.delete(); exp_rc = 3'd7; end
      2'd1: begin
        if (model.exists(key)) begin exp_rc = 3'd0; exp_fv = model[key]; end
        else exp_rc = 3'd1;
      end
      2'd2: begin
        if (model.exists(key)) begin exp_rc = 3'd3; model[key] = val; end
        else if (model.num() < CAPACITY) begin exp_rc = 3'd2; model[key] = val; end
        else exp_rc = 3'd4;
      end
      default: begin
        if (model.exists(key)) begin exp_rc = 3'd5; model.delete(key); end
        else exp_rc = 3'd6;
      end
    endcase

    @(negedge clk);
    ifc.cmd_valid_i  = 1'b1;
    ifc.cmd_opcode_i = op;
    ifc.cmd_key_i    = key;
    ifc.cmd_value_i  = val;
    cyc = 0;
    while (!ifc.cmd_ready_o && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    ok = ifc.cmd_ready_o;
    check("cmd_accept", 80'(ok), 80'(1));
    @(posedge clk);
    #1 ifc.cmd_valid_i = 1'b0;

    if (ok) begin
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 3000) begin
        @(negedge clk);
        ifc.res_ready_i = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (ifc.res_valid_o && ifc.res_ready_i) got = 1'b1;
        cyc++;
      end
      check("res_handshake", 80'(got), 80'(1));
      if (got) begin
        check("rescode", 80'(ifc.res_rescode_o), 80'(exp_rc));
        check("found_value", 80'(ifc.res_found_value_o), 80'(exp_fv));
        check("echo_op_key_val_bucket",
              80'({ifc.res_opcode_o, ifc.res_key_o, ifc.res_value_o, ifc.res_bucket_o}),
              80'({op, key, val, key[31:24]}));
      end
      @(posedge clk);
      #1 ifc.res_ready_i = 1'b0;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] k;
    logic [31:0] first_key;
    logic [1:0]  op;
    int          r;
    int          cyc;

    rst_n = 1'b0;
    ifc.cmd_valid_i  = 1'b0;
    ifc.cmd_opcode_i = '0;
    ifc.cmd_key_i    = '0;
    ifc.cmd_value_i  = '0;
    ifc.res_ready_i  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          80'({ifc.cmd_ready_o, ifc.res_valid_o, ifc.res_opcode_o, ifc.res_key_o, ifc.res_value_o,
               ifc.res_rescode_o, ifc.res_bucket_o, ifc.res_found_value_o}), 80'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("ready_low_during_auto_init", 80'(ifc.cmd_ready_o), 80'(0));
    cyc = 0;
    while (!ifc.cmd_ready_o && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_after_auto_init", 80'(ifc.cmd_ready_o), 80'(1));

    // Basic insert/search and same-key overwrite.
    run_cmd(OP_INIT,   32'h0000_0000, 16'h0000, 1'b0);
    run_cmd(OP_INSERT, 32'h0100_0000, 16'h1234, 1'b0);
    run_cmd(OP_INSERT, 32'h0100_1000, 16'h1235, 1'b0);
    run_cmd(OP_SEARCH, 32'h0100_1000, 16'h0000, 1'b0);
    run_cmd(OP_INSERT, 32'h0100_0000, 16'hAAAA, 1'b0);
    run_cmd(OP_SEARCH, 32'h0100_0000, 16'h0000, 1'b0);

    // Chain of six: delete middle, head and tail, then search all.
    for (int i = 0; i < 6; i++) run_cmd(OP_INSERT, 32'h0400_0000 + 32'(i), 16'(16'h0B00 + i), 1'b0);
    run_cmd(OP_DELETE, 32'h0400_0002, 16'h0000, 1'b0);
    run_cmd(OP_DELETE, 32'h0400_0000, 16'h0000, 1'b0);
    run_cmd(OP_DELETE, 32'h0400_0005, 16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) run_cmd(OP_SEARCH, 32'h0400_0000 + 32'(i), 16'h0000, 1'b0);
    run_cmd(OP_SEARCH, 32'h0410_0000, 16'h0000, 1'b0);
    run_cmd(OP_DELETE, 32'h0411_1111, 16'h0000, 1'b0);

    // Fill to capacity and beyond, then free one slot and reuse it.
    run_cmd(OP_INIT, 32'h0, 16'h0, 1'b0);
    first_key = '0;
    for (int i = 0; i < CAPACITY + 10; i++) begin
      k = $urandom;
      while (model.exists(k)) k = $urandom;
      if (i == 0) first_key = k;
      run_cmd(OP_INSERT, k, 16'($urandom), 1'b0);
    end
    run_cmd(OP_DELETE, first_key, 16'h0, 1'b0);
    k = $urandom;
    while (model.exists(k)) k = $urandom;
    run_cmd(OP_INSERT, k, 16'h7777, 1'b0);

    // Random mix over 16 buckets x 8 keys with random result backpressure.
    run_cmd(OP_INIT, 32'h0, 16'h0, 1'b0);
    for (int n = 0; n < 2500; n++) begin
      r  = $urandom_range(0, 199);
      op = (r == 0) ? 2'd0 : (r < 70) ? 2'd1 : (r < 140) ? 2'd2 : 2'd3;
      k  = {8'h20 + 8'($urandom_range(0, 15)), 8'h5A, 8'($urandom_range(0, 7)), 8'hC3};
      run_cmd(op, k, 16'($urandom), 1'b1);
    end

    // Reset in the middle of a command wipes the table.
    run_cmd(OP_INSERT, 32'h0A00_0001, 16'h5555, 1'b0);
    @(negedge clk);
    ifc.cmd_valid_i  = 1'b1;
    ifc.cmd_opcode_i = OP_INSERT;
    ifc.cmd_key_i    = 32'h0A00_0002;
    ifc.cmd_value_i  = 16'h6666;
    @(posedge clk);
    #1 ifc.cmd_valid_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("abort_outputs", 80'({ifc.cmd_ready_o, ifc.res_valid_o, ifc.res_rescode_o, ifc.res_key_o}), 80'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    model.delete();
    run_cmd(OP_SEARCH, 32'h0A00_0001, 16'h0, 1'b0);
    run_cmd(OP_SEARCH, 32'h0A00_0002, 16'h0, 1'b0);
    run_cmd(OP_INSERT, 32'h0A00_0003, 16'h9999, 1'b0);
    run_cmd(OP_SEARCH, 32'h0A00_0003, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
